ysyx_22041405_wbu: RTL and testbench

- Write-back stage directly upstream of the 32-entry register file. It drives that file's write address and write data ports.
- Accepts completed instructions from EXU/LSU over a valid/ready handshake.
- For loads, waits for the memory response, then aligns and sign- or zero-extends the loaded data.
- Emits a one-cycle commit pulse with the instruction's PC for difftest/trace.

---
 rtl/ysyx_22041405_wbu_pkg.sv | 17 +
 rtl/ysyx_22041405_load_ext.sv | 53 +++++
 rtl/ysyx_22041405_wbu.sv | 129 ++++++++++++
 tb/tb_ysyx_22041405_wbu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041405_wbu_pkg.sv
// Shared constants for the write-back stage: load funct3 codes, FSM encoding, x0 sink.
package ysyx_22041405_wbu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_22041405_load_ext.sv
// Load data extraction: selects byte/half/word from an aligned word and extends it.
// Purely combinational; err flags misaligned accesses and unknown funct3 (data forced 0).
module ysyx_22041405_load_ext
  import ysyx_22041405_wbu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            load_op,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (addr_lo)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (load_op)
      LB:  data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      LH:  begin
        err  = addr_lo[0];
        data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      end
      LHU: begin
        err  = addr_lo[0];
        data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      end
      LW:  begin
        err  = (addr_lo != 2'd0);
        data = raw;
      end
      default: err = 1'b1;
    endcase
    if (err) data = '0;
  end

endmodule

// File: rtl/ysyx_22041405_wbu.sv
// Write-back stage: retires one non-load per cycle, loads commit the cycle after mem_rvalid.
// All outputs registered and zero when idle (the register file writes every clock, x0 absorbs it).
module ysyx_22041405_wbu
  import ysyx_22041405_wbu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_op,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic                  load_err
);

  localparam logic [ADDR_WIDTH-1:0] RD_ZERO = ADDR_WIDTH'(ZERO_REG);

  wbu_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] hold_rd;
  logic                  hold_wen;
  logic [2:0]            hold_op;
  logic [1:0]            hold_addr_lo;
  logic [DATA_WIDTH-1:0] hold_pc;

  logic [DATA_WIDTH-1:0] ext_data;
  logic                  ext_err;

  logic [ADDR_WIDTH-1:0] waddr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic                  commit_nxt;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic                  err_nxt;
  logic                  load_accept;

  assign in_ready    = (state == IDLE) && !rst;
  assign load_accept = in_valid && in_ready && in_is_load;

  ysyx_22041405_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .load_op (hold_op),
    .addr_lo (hold_addr_lo),
    .raw     (mem_rdata),
    .data    (ext_data),
    .err     (ext_err)
  );

  always_comb begin
    state_nxt  = state;
    waddr_nxt  = RD_ZERO;
    wdata_nxt  = '0;
    commit_nxt = 1'b0;
    pc_nxt     = '0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in_is_load) begin
            state_nxt = WAIT_MEM;
          end else begin
            commit_nxt = 1'b1;
            pc_nxt     = in_pc;
            // rd=x0 still gets zero data so the sink write is deterministic
            if (in_rd_wen && in_rd != RD_ZERO) begin
              waddr_nxt = in_rd;
              wdata_nxt = in_result;
            end
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_nxt  = IDLE;
          commit_nxt = 1'b1;
          pc_nxt     = hold_pc;
          err_nxt    = ext_err;
          if (!ext_err && hold_wen && hold_rd != RD_ZERO) begin
            waddr_nxt = hold_rd;
            wdata_nxt = ext_data;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rf_waddr     <= RD_ZERO;
      rf_wdata     <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      load_err     <= 1'b0;
      hold_rd      <= RD_ZERO;
      hold_wen     <= 1'b0;
      hold_op      <= 3'b000;
      hold_addr_lo <= 2'b00;
      hold_pc      <= '0;
    end else begin
      state        <= state_nxt;
      rf_waddr     <= waddr_nxt;
      rf_wdata     <= wdata_nxt;
      commit_valid <= commit_nxt;
      commit_pc    <= pc_nxt;
      load_err     <= err_nxt;
      if (load_accept) begin
        hold_rd      <= in_rd;
        hold_wen     <= in_rd_wen;
        hold_op      <= in_load_op;
        hold_addr_lo <= in_addr_lo;
        hold_pc      <= in_pc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041405_wbu.sv
// Directed bench for the write-back stage with hand-computed expectations.
module tb_ysyx_22041405_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_load_op;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic [31:0] in_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22041405_wbu #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_rd_wen    (in_rd_wen),
    .in_is_load   (in_is_load),
    .in_load_op   (in_load_op),
    .in_addr_lo   (in_addr_lo),
    .in_result    (in_result),
    .in_pc        (in_pc),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .load_err     (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic cv, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pc, input logic le);
    chk({tag, ".commit_valid"}, {31'd0, commit_valid}, {31'd0, cv});
    chk({tag, ".rf_waddr"}, {27'd0, rf_waddr}, {27'd0, wa});
    chk({tag, ".rf_wdata"}, rf_wdata, wd);
    chk({tag, ".commit_pc"}, commit_pc, pc);
    chk({tag, ".load_err"}, {31'd0, load_err}, {31'd0, le});
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic wen,
                           input logic [31:0] res, input logic [31:0] pc);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_result  = res;
    in_pc      = pc;
  endtask

  // Accept a load, wait one cycle in WAIT_MEM, then respond; leaves sampling point on the commit cycle.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] alo,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rdata);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_load_op = op;
    in_addr_lo = alo;
    in_rd      = rd;
    in_rd_wen  = 1'b1;
    in_pc      = pc;
    in_result  = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk({tag, ".wait_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, ".wait_commit"}, {31'd0, commit_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, ".ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_rd      = 5'd0;
    in_rd_wen  = 1'b0;
    in_is_load = 1'b0;
    in_load_op = 3'b000;
    in_addr_lo = 2'b00;
    in_result  = 32'd0;
    in_pc      = 32'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;

    tick();
    tick();
    chk_out("reset", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset.in_ready", {31'd0, in_ready}, 32'd1);

    // back-to-back non-loads
    issue_alu(5'd5, 1'b1, 32'h0000_1234, 32'h8000_0000);
    tick();
    chk_out("alu0", 1'b1, 5'd5, 32'h0000_1234, 32'h8000_0000, 1'b0);
    issue_alu(5'd6, 1'b1, 32'h0000_000A, 32'h8000_0004);
    tick();
    chk_out("alu1", 1'b1, 5'd6, 32'h0000_000A, 32'h8000_0004, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_out("idle0", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

    // lb at byte 3 of 0x80FF0011 -> 0x80 sign-extended
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_load_op = 3'b000;
    in_addr_lo = 2'd3;
    in_rd      = 5'd7;
    in_rd_wen  = 1'b1;
    in_pc      = 32'h8000_0008;
    tick();
    in_valid = 1'b0;
    chk("lb.ready_w1", {31'd0, in_ready}, 32'd0);
    chk_out("lb.wait1", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    chk("lb.ready_w2", {31'd0, in_ready}, 32'd0);
    chk_out("lb.wait2", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_0011;
    tick();
    mem_rvalid = 1'b0;
    chk_out("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 32'h8000_0008, 1'b0);
    chk("lb.ready_after", {31'd0, in_ready}, 32'd1);

    do_load("lbu", 3'b100, 2'd2, 5'd8, 32'h8000_000C, 32'h80FF_0011);
    chk_out("lbu", 1'b1, 5'd8, 32'h0000_00FF, 32'h8000_000C, 1'b0);
    do_load("lhu", 3'b101, 2'd2, 5'd12, 32'h8000_0010, 32'hBEEF_1234);
    chk_out("lhu", 1'b1, 5'd12, 32'h0000_BEEF, 32'h8000_0010, 1'b0);
    do_load("lh", 3'b001, 2'd2, 5'd13, 32'h8000_0014, 32'hBEEF_1234);
    chk_out("lh", 1'b1, 5'd13, 32'hFFFF_BEEF, 32'h8000_0014, 1'b0);
    do_load("lh_lo", 3'b001, 2'd0, 5'd14, 32'h8000_0018, 32'hBEEF_8234);
    chk_out("lh_lo", 1'b1, 5'd14, 32'hFFFF_8234, 32'h8000_0018, 1'b0);
    do_load("lw", 3'b010, 2'd0, 5'd15, 32'h8000_001C, 32'hBEEF_1234);
    chk_out("lw", 1'b1, 5'd15, 32'hBEEF_1234, 32'h8000_001C, 1'b0);

    // error loads: write suppressed, commit still pulses
    do_load("lw_mis", 3'b010, 2'd2, 5'd16, 32'h8000_0020, 32'hBEEF_1234);
    chk_out("lw_mis", 1'b1, 5'd0, 32'd0, 32'h8000_0020, 1'b1);
    do_load("lh_mis", 3'b001, 2'd1, 5'd17, 32'h8000_0024, 32'hBEEF_1234);
    chk_out("lh_mis", 1'b1, 5'd0, 32'd0, 32'h8000_0024, 1'b1);
    do_load("f3_011", 3'b011, 2'd0, 5'd18, 32'h8000_0028, 32'hBEEF_1234);
    chk_out("f3_011", 1'b1, 5'd0, 32'd0, 32'h8000_0028, 1'b1);

    // no-write paths and mem_rvalid ignored while idle
    issue_alu(5'd9, 1'b0, 32'hDEAD_0001, 32'h8000_0030);
    tick();
    chk_out("nowen", 1'b1, 5'd0, 32'd0, 32'h8000_0030, 1'b0);
    issue_alu(5'd0, 1'b1, 32'hDEAD_0002, 32'h8000_0034);
    tick();
    chk_out("rd0", 1'b1, 5'd0, 32'd0, 32'h8000_0034, 1'b0);
    in_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    chk_out("idle_rvalid", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

    // reset while waiting for memory
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_load_op = 3'b010;
    in_addr_lo = 2'd0;
    in_rd      = 5'd10;
    in_rd_wen  = 1'b1;
    in_pc      = 32'h8000_0040;
    tick();
    in_valid = 1'b0;
    chk("rstmid.wait_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    chk_out("rstmid.rst", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    #1;
    chk("rstmid.ready", {31'd0, in_ready}, 32'd1);
    tick();
    mem_rvalid = 1'b0;
    chk_out("rstmid.late_rvalid", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    issue_alu(5'd11, 1'b1, 32'h0000_0055, 32'h8000_0044);
    tick();
    in_valid = 1'b0;
    chk_out("rstmid.alu", 1'b1, 5'd11, 32'h0000_0055, 32'h8000_0044, 1'b0);
    tick();
    chk_out("final_idle", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
